snake_game_engine: RTL and testbench



---
 rtl/snake_game_engine.sv | 180 ++++++++++++++++++
 tb/tb_snake_game_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_game_engine.sv
// snake_game_engine
//   Two-player snake game state engine feeding the VGA controller.
//   Samples direction buttons, advances both snakes on a 40x40 board once per
//   move tick, resolves wall / head-to-head collisions, apple eating with
//   growth, and the hearts countdown. The full state is published as the
//   488-bit snake_data bus, built purely from registers.
// Ports:
//   iVGA_CLK            system clock
//   iRST_n              synchronous active-low reset
//   start               level, start/restart game from idle or game over
//   up/down/left/right  player-1 direction buttons
//   up2/down2/left2/right2 player-2 direction buttons
//   snake_data[487:0]   packed game state
//   move_tick           one-cycle pulse on the cycle the state updates
module snake_game_engine #(
  parameter int unsigned TICK_DIV   = 2500000,
  parameter int unsigned HEARTS_MAX = 100,
  parameter int unsigned INIT_LEN   = 3
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         start,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  input  logic         up2,
  input  logic         down2,
  input  logic         left2,
  input  logic         right2,
  output logic [487:0] snake_data,
  output logic         move_tick
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd2,
    ST_OVER = 2'd3
  } stage_t;

  stage_t       r_stage, w_stage_nxt;
  logic [99:0]  r_ring1, r_ring2;
  logic [10:0]  r_head1, r_head2, r_apple, r_lfsr;
  logic [5:0]   r_len1, r_len2, r_idx1, r_idx2;
  logic [31:0]  r_hearts, r_cnt;
  logic [1:0]   r_cur1, r_cur2, r_pend1, r_pend2;
  logic         r_move_tick;

  logic         w_move, w_hit, w_adv, w_init, w_eat1, w_eat2;
  logic         w_wall1, w_wall2, w_acc1, w_acc2;
  logic [10:0]  w_nh1, w_nh2, w_new_apple;
  logic [5:0]   w_nidx1, w_nidx2;
  logic [2:0]   w_req1, w_req2;
  logic [1:0]   w_ref1, w_ref2;

  // {wall_hit, next_head}; the wall test uses the current position only.
  function automatic logic [11:0] step(input logic [10:0] h, input logic [1:0] d);
    logic [10:0] col;
    logic        wall;
    logic [10:0] nh;
    col = h % 11'd40;
    case (d)
      2'b00:   begin wall = (h < 11'd40);     nh = h - 11'd40; end
      2'b01:   begin wall = (col == 11'd39);  nh = h + 11'd1;  end
      2'b10:   begin wall = (h >= 11'd1560);  nh = h + 11'd40; end
      default: begin wall = (col == 11'd0);   nh = h - 11'd1;  end
    endcase
    return {wall, nh};
  endfunction

  // {valid, dir} with priority up > down > left > right.
  function automatic logic [2:0] req(input logic u, input logic dn, input logic l, input logic r);
    if (u)       return 3'b100;
    else if (dn) return 3'b110;
    else if (l)  return 3'b111;
    else if (r)  return 3'b101;
    else         return 3'b000;
  endfunction

  always_comb begin
    w_move  = (r_stage == ST_PLAY) && (r_cnt == TICK_DIV - 1);
    {w_wall1, w_nh1} = step(r_head1, r_pend1);
    {w_wall2, w_nh2} = step(r_head2, r_pend2);
    w_hit   = w_wall1 || w_wall2 || (w_nh1 == w_nh2) || (w_nh1 == r_head2) ||
              (w_nh2 == r_head1) || (r_hearts == '0);
    w_adv   = w_move && !w_hit;
    w_init  = start && ((r_stage == ST_IDLE) || (r_stage == ST_OVER));
    w_eat1  = (w_nh1 == r_apple);
    w_eat2  = (w_nh2 == r_apple);
    w_nidx1 = (r_idx1 == 6'd0) ? 6'd49 : r_idx1 - 6'd1;
    w_nidx2 = (r_idx2 == 6'd0) ? 6'd49 : r_idx2 - 6'd1;
    w_new_apple = (r_lfsr >= 11'd1600) ? r_lfsr - 11'd1600 : r_lfsr;
    w_req1  = req(up, down, left, right);
    w_req2  = req(up2, down2, left2, right2);
    // A request on the move cycle is judged against the direction being taken.
    w_ref1  = w_adv ? r_pend1 : r_cur1;
    w_ref2  = w_adv ? r_pend2 : r_cur2;
    w_acc1  = w_req1[2] && (w_req1[1:0] != (w_ref1 ^ 2'b10));
    w_acc2  = w_req2[2] && (w_req2[1:0] != (w_ref2 ^ 2'b10));
  end

  always_comb begin
    w_stage_nxt = r_stage;
    case (r_stage)
      ST_IDLE, ST_OVER: if (start) w_stage_nxt = ST_PLAY;
      ST_PLAY:          if (w_move && w_hit) w_stage_nxt = ST_OVER;
      default:          w_stage_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) r_stage <= ST_IDLE;
    else         r_stage <= w_stage_nxt;
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      r_lfsr      <= 11'd1;
      r_move_tick <= 1'b0;
    end else begin
      r_lfsr      <= {r_lfsr[9:0], r_lfsr[10] ^ r_lfsr[8]};
      r_move_tick <= w_move;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n || w_init) begin
      r_ring1  <= {50{2'b11}};
      r_ring2  <= {50{2'b01}};
      r_head1  <= 11'd810;
      r_head2  <= 11'd830;
      r_len1   <= 6'(INIT_LEN);
      r_len2   <= 6'(INIT_LEN);
      r_idx1   <= '0;
      r_idx2   <= '0;
      r_cur1   <= 2'b01;
      r_cur2   <= 2'b11;
      r_pend1  <= 2'b01;
      r_pend2  <= 2'b11;
      r_apple  <= 11'd425;
      r_hearts <= HEARTS_MAX;
      r_cnt    <= '0;
    end else if (r_stage == ST_PLAY) begin
      r_cnt <= w_move ? '0 : r_cnt + 32'd1;
      if (w_acc1) r_pend1 <= w_req1[1:0];
      if (w_acc2) r_pend2 <= w_req2[1:0];
      if (w_adv) begin
        r_idx1 <= w_nidx1;
        r_idx2 <= w_nidx2;
        r_ring1[{w_nidx1, 1'b0} +: 2] <= r_pend1 ^ 2'b10;
        r_ring2[{w_nidx2, 1'b0} +: 2] <= r_pend2 ^ 2'b10;
        r_cur1  <= r_pend1;
        r_cur2  <= r_pend2;
        r_head1 <= w_nh1;
        r_head2 <= w_nh2;
        if (w_eat1 || w_eat2) begin
          if (w_eat1 && r_len1 != 6'd49) r_len1 <= r_len1 + 6'd1;
          if (w_eat2 && r_len2 != 6'd49) r_len2 <= r_len2 + 6'd1;
          r_hearts <= HEARTS_MAX;
          r_apple  <= w_new_apple;
        end else begin
          r_hearts <= r_hearts - 32'd1;
        end
      end
    end
  end

  assign move_tick  = r_move_tick;
  assign snake_data = {r_hearts,
                       21'd0, r_apple,
                       26'd0, r_idx2,
                       26'd0, r_idx1,
                       30'd0, r_stage,
                       26'd0, r_len2,
                       26'd0, r_len1,
                       21'd0, r_head2,
                       21'd0, r_head1,
                       r_ring2, r_ring1};

endmodule

// File: tb/tb_snake_game_engine.sv
// tb_snake_game_engine
//   Scoreboard bench for snake_game_engine with TICK_DIV=4. A tick-level game
//   model predicts each move; predictions are queued when the buttons for
//   that tick are driven and compared when move_tick is seen.
module tb_snake_game_engine;
  localparam int unsigned TICK_DIV   = 4;
  localparam int unsigned HEARTS_MAX = 100;
  localparam int unsigned INIT_LEN   = 3;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic up2 = 1'b0, down2 = 1'b0, left2 = 1'b0, right2 = 1'b0;
  logic [487:0] snake_data;
  logic         move_tick;

  always #5 clk = ~clk;

  snake_game_engine #(.TICK_DIV(TICK_DIV), .HEARTS_MAX(HEARTS_MAX), .INIT_LEN(INIT_LEN)) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .start(start),
    .up(up), .down(down), .left(left), .right(right),
    .up2(up2), .down2(down2), .left2(left2), .right2(right2),
    .snake_data(snake_data), .move_tick(move_tick)
  );

  int n_checks = 0, n_fail = 0;

  int m_head1, m_head2, m_len1, m_len2, m_stage, m_idx1, m_idx2, m_apple, m_hearts;
  logic [1:0]  m_cur1, m_cur2, m_pend1, m_pend2;
  logic [1:0]  m_r1 [50];
  logic [1:0]  m_r2 [50];
  logic [10:0] m_lfsr;

  typedef struct packed {
    logic [31:0] head1, head2, len1, len2, stage, idx1, idx2, apple, hearts;
    logic [1:0]  r1, r2;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int k);
    return snake_data[200 + 32*k +: 32];
  endfunction

  function automatic logic [10:0] lstep(input logic [10:0] x);
    return {x[9:0], x[10] ^ x[8]};
  endfunction

  // One clock: the LFSR model follows the DUT's free-running register.
  task automatic cyc();
    @(posedge clk);
    m_lfsr = rst_n ? lstep(m_lfsr) : 11'd1;
    @(negedge clk);
  endtask

  task automatic model_init(input int stage);
    m_stage = stage; m_head1 = 810; m_head2 = 830;
    m_len1 = INIT_LEN; m_len2 = INIT_LEN; m_idx1 = 0; m_idx2 = 0;
    m_cur1 = 2'b01; m_cur2 = 2'b11; m_pend1 = 2'b01; m_pend2 = 2'b11;
    m_apple = 425; m_hearts = HEARTS_MAX;
    for (int i = 0; i < 50; i++) begin m_r1[i] = 2'b11; m_r2[i] = 2'b01; end
  endtask

  // b = {up, down, left, right}
  function automatic logic [1:0] samp(input logic [3:0] b, input logic [1:0] cur, input logic [1:0] pend);
    logic [1:0] r;
    if (b[3])      r = 2'b00;
    else if (b[2]) r = 2'b10;
    else if (b[1]) r = 2'b11;
    else if (b[0]) r = 2'b01;
    else return pend;
    return (r == (cur ^ 2'b10)) ? pend : r;
  endfunction

  function automatic bit is_wall(input int h, input logic [1:0] d);
    case (d)
      2'b00:   return h < 40;
      2'b01:   return (h % 40) == 39;
      2'b10:   return h >= 1560;
      default: return (h % 40) == 0;
    endcase
  endfunction

  function automatic int delta(input logic [1:0] d);
    case (d)
      2'b00:   return -40;
      2'b01:   return 1;
      2'b10:   return 40;
      default: return -1;
    endcase
  endfunction

  task automatic model_move(input logic [10:0] v);
    int nh1, nh2;
    bit eat1, eat2;
    if (m_stage != 2) return;
    nh1 = m_head1 + delta(m_pend1);
    nh2 = m_head2 + delta(m_pend2);
    if (is_wall(m_head1, m_pend1) || is_wall(m_head2, m_pend2) || nh1 == nh2 ||
        nh1 == m_head2 || nh2 == m_head1 || m_hearts == 0) begin
      m_stage = 3;
      return;
    end
    m_idx1 = (m_idx1 + 49) % 50; m_r1[m_idx1] = m_pend1 ^ 2'b10; m_cur1 = m_pend1; m_head1 = nh1;
    m_idx2 = (m_idx2 + 49) % 50; m_r2[m_idx2] = m_pend2 ^ 2'b10; m_cur2 = m_pend2; m_head2 = nh2;
    eat1 = (nh1 == m_apple);
    eat2 = (nh2 == m_apple);
    if (eat1 || eat2) begin
      if (eat1 && m_len1 < 49) m_len1++;
      if (eat2 && m_len2 < 49) m_len2++;
      m_hearts = HEARTS_MAX;
      m_apple  = (int'(v) >= 1600) ? int'(v) - 1600 : int'(v);
    end else begin
      m_hearts--;
    end
  endtask

  task automatic check_model(input string p);
    logic [99:0] e1, e2;
    for (int i = 0; i < 50; i++) begin e1[2*i +: 2] = m_r1[i]; e2[2*i +: 2] = m_r2[i]; end
    check({p, "_head1"},  fld(0), m_head1);
    check({p, "_head2"},  fld(1), m_head2);
    check({p, "_len1"},   fld(2), m_len1);
    check({p, "_len2"},   fld(3), m_len2);
    check({p, "_stage"},  fld(4), m_stage);
    check({p, "_idx1"},   fld(5), m_idx1);
    check({p, "_idx2"},   fld(6), m_idx2);
    check({p, "_apple"},  fld(7), m_apple);
    check({p, "_hearts"}, fld(8), m_hearts);
    check({p, "_ring1"},  snake_data[99:0], e1);
    check({p, "_ring2"},  snake_data[199:100], e2);
    check({p, "_mtick"},  move_tick, 1'b0);
  endtask

  // Called on the negedge right after a move or start edge (counter at 0).
  task automatic tick(input logic [3:0] b1, input logic [3:0] b2);
    exp_t e;
    logic [10:0] v;
    int n;
    m_pend1 = samp(b1, m_cur1, m_pend1);
    m_pend2 = samp(b2, m_cur2, m_pend2);
    v = m_lfsr;
    for (int i = 0; i < int'(TICK_DIV) - 1; i++) v = lstep(v);
    model_move(v);
    e.head1 = m_head1; e.head2 = m_head2; e.len1 = m_len1; e.len2 = m_len2;
    e.stage = m_stage; e.idx1 = m_idx1; e.idx2 = m_idx2; e.apple = m_apple;
    e.hearts = m_hearts; e.r1 = m_r1[m_idx1]; e.r2 = m_r2[m_idx2];
    sb.push_back(e);
    {up, down, left, right} = b1;
    {up2, down2, left2, right2} = b2;
    cyc();
    {up, down, left, right} = 4'b0;
    {up2, down2, left2, right2} = 4'b0;
    n = 0;
    while (!move_tick && n < 16) begin cyc(); n++; end
    check("move_tick", move_tick, 1'b1);
    if (move_tick && sb.size() > 0) begin
      e = sb.pop_front();
      check("t_head1",  fld(0), e.head1);
      check("t_head2",  fld(1), e.head2);
      check("t_len1",   fld(2), e.len1);
      check("t_len2",   fld(3), e.len2);
      check("t_stage",  fld(4), e.stage);
      check("t_idx1",   fld(5), e.idx1);
      check("t_idx2",   fld(6), e.idx2);
      check("t_apple",  fld(7), e.apple);
      check("t_hearts", fld(8), e.hearts);
      check("t_ring1",  snake_data[2*int'(e.idx1) +: 2], e.r1);
      check("t_ring2",  snake_data[100 + 2*int'(e.idx2) +: 2], e.r2);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    if (m_stage == 0 || m_stage == 3) model_init(2);
    cyc();
    start = 1'b0;
    check_model("start");
  endtask

  // Small closed loops that never meet each other or a wall.
  function automatic logic [3:0] c1(input int k);
    case (k % 4)
      0: return 4'b0100; 1: return 4'b0010; 2: return 4'b1000; default: return 4'b0001;
    endcase
  endfunction
  function automatic logic [3:0] c2(input int k);
    case (k % 4)
      0: return 4'b1000; 1: return 4'b0001; 2: return 4'b0100; default: return 4'b0010;
    endcase
  endfunction

  initial begin
    int k;
    bit seen;
    m_lfsr = 11'd1;
    rst_n = 1'b0;
    repeat (3) cyc();
    model_init(0);
    check_model("reset");
    rst_n = 1'b1;
    cyc();
    check_model("idle");

    // First move, reversal rejection, turn down, then run into the right wall.
    do_start();
    tick(4'b0000, 4'b0000);
    k = 0;
    tick(4'b0010, c2(k)); k++;
    tick(4'b0100, c2(k)); k++;
    tick(4'b0001, c2(k)); k++;
    while (m_head1 % 40 != 39 && k < 60) begin tick(4'b0000, c2(k)); k++; end
    tick(4'b0000, c2(k));
    check("wall_stage", fld(4), 3);

    // Game over is frozen; buttons and waiting change nothing.
    seen = 1'b0;
    up = 1'b1; down2 = 1'b1;
    repeat (12) begin cyc(); if (move_tick) seen = 1'b1; end
    up = 1'b0; down2 = 1'b0;
    check("frozen_tick", seen, 1'b0);
    check_model("frozen");

    // Hearts run out while both snakes circle.
    do_start();
    k = 0;
    while (m_stage == 2 && k < 120) begin tick(c1(k), c2(k)); k++; end
    check("hearts_stage", fld(4), 3);
    check("hearts_zero",  fld(8), 0);

    // Steer snake 1 onto the apple at 425.
    do_start();
    k = 0;
    repeat (15) begin tick(4'b0000, c2(k)); k++; end
    tick(4'b1000, c2(k)); k++;
    repeat (9) begin tick(4'b0000, c2(k)); k++; end
    check("apple_len1",   fld(2), 4);
    check("apple_hearts", fld(8), HEARTS_MAX);
    check("apple_range",  fld(7) < 1600, 1'b1);
    repeat (2) begin tick(4'b0000, c2(k)); k++; end

    // Reset mid-game, then buttons while idle are ignored.
    rst_n = 1'b0;
    cyc();
    model_init(0);
    check_model("midrst");
    rst_n = 1'b1;
    down = 1'b1; up2 = 1'b1;
    cyc();
    down = 1'b0; up2 = 1'b0;
    cyc();
    check_model("idle_btn");
    do_start();
    tick(4'b0000, 4'b0000);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
